trace_capture: RTL and testbench

Parametrised on-chip trace buffer for the tiny16 core. It samples up to CHANNELS probe words (bus, step counter, instruction, ALU output, and so on) on each qualified clock into a circular buffer. It stops a programmable number of samples after a masked-compare trigger, then replays the window oldest-first over a valid/ready port. This gives silicon and long-running simulation the same per-step visibility the core bench gets from printing internal nets every step.

---
 rtl/trace_capture.sv | 133 +++++++++++++
 tb/tb_trace_capture.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/trace_capture.sv
// ============================================================================
//  Module   : trace_capture
//  Purpose  : Circular trace buffer. Stops after a masked-compare trigger plus
//             a programmable post count. Replays oldest-first over valid/ready.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module trace_capture #(
  parameter  int WIDTH    = 16,
  parameter  int CHANNELS = 4,
  parameter  int DEPTH    = 16,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] ch_in,
  input  logic                      sample_en,
  input  logic                      arm,
  input  logic [WIDTH-1:0]          trig_value,
  input  logic [WIDTH-1:0]          trig_mask,
  input  logic                      force_trig,
  input  logic [AW-1:0]             post_count,
  output logic [1:0]                state,
  output logic                      rd_valid,
  input  logic                      rd_ready,
  output logic [CHANNELS*WIDTH-1:0] rd_data,
  output logic                      rd_last,
  output logic [AW-1:0]             trig_index
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_POST    = 2'd2,
    S_READOUT = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [AW-1:0]       r_wptr;
  logic [AW:0]         r_fill;
  logic [AW-1:0]       r_post_lat;
  logic [AW-1:0]       r_remain;
  logic [AW-1:0]       r_rptr;
  logic [AW:0]         r_words;
  logic [AW-1:0]       r_trig_index;
  logic [CHANNELS*WIDTH-1:0] r_mem [DEPTH];

  logic                w_hit;
  logic                w_wr_en;
  logic                w_enter_rd;
  logic [AW-1:0]       w_wptr_n;
  logic [AW:0]         w_fill_n;
  logic [AW:0]         w_tidx_full;

  assign w_hit    = sample_en &&
                    (force_trig ||
                     ((ch_in[WIDTH-1:0] & trig_mask) == (trig_value & trig_mask)));
  assign w_wr_en  = !arm && sample_en && (r_state == S_ARMED || r_state == S_POST);
  assign w_wptr_n = r_wptr + AW'(1);
  assign w_fill_n = (r_fill == (AW+1)'(DEPTH)) ? r_fill : r_fill + (AW+1)'(1);
  assign w_tidx_full = w_fill_n - (AW+1)'(1) - {1'b0, r_post_lat};
  assign w_enter_rd  = (r_state != S_READOUT) && (w_next == S_READOUT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (arm) begin
      w_next = S_ARMED;
    end else begin
      case (r_state)
        S_ARMED:   if (w_hit) w_next = (r_post_lat == '0) ? S_READOUT : S_POST;
        S_POST:    if (sample_en && r_remain == AW'(1)) w_next = S_READOUT;
        S_READOUT: if (rd_ready && r_words == (AW+1)'(1)) w_next = S_IDLE;
        default:   w_next = r_state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr       <= '0;
      r_fill       <= '0;
      r_post_lat   <= '0;
      r_remain     <= '0;
      r_rptr       <= '0;
      r_words      <= '0;
      r_trig_index <= '0;
    end else if (arm) begin
      r_wptr     <= '0;
      r_fill     <= '0;
      r_post_lat <= post_count;
      r_remain   <= '0;
    end else begin
      if (w_wr_en) begin
        r_wptr <= w_wptr_n;
        r_fill <= w_fill_n;
      end
      if (r_state == S_ARMED && w_hit)
        r_remain <= r_post_lat;
      if (r_state == S_POST && sample_en)
        r_remain <= r_remain - AW'(1);
      // Oldest sample sits fill entries behind the post-write pointer.
      if (w_enter_rd) begin
        r_rptr       <= w_wptr_n - w_fill_n[AW-1:0];
        r_words      <= w_fill_n;
        r_trig_index <= w_tidx_full[AW-1:0];
      end
      if (r_state == S_READOUT && rd_ready) begin
        r_rptr  <= r_rptr + AW'(1);
        r_words <= r_words - (AW+1)'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wptr] <= ch_in;
  end

  assign state      = r_state;
  assign rd_valid   = (r_state == S_READOUT);
  assign rd_data    = rd_valid ? r_mem[r_rptr] : '0;
  assign rd_last    = rd_valid && (r_words == (AW+1)'(1));
  assign trig_index = r_trig_index;

endmodule

`default_nettype wire

// File: tb/tb_trace_capture.sv
// ============================================================================
//  Module   : tb_trace_capture
//  Purpose  : Directed vector bench for trace_capture (WIDTH=16, CHANNELS=2, DEPTH=8).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_trace_capture;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] ch0;
  logic [31:0] ch_in;
  logic        sample_en, arm, force_trig, rd_ready;
  logic [15:0] trig_value, trig_mask;
  logic [2:0]  post_count;
  logic [1:0]  state;
  logic        rd_valid, rd_last;
  logic [31:0] rd_data;
  logic [2:0]  trig_index;

  int vectors    = 0;
  int miscompares = 0;

  // Channel 1 carries the bitwise complement of channel 0.
  assign ch_in = {~ch0, ch0};

  always #5 clk = ~clk;

  trace_capture #(.WIDTH(16), .CHANNELS(2), .DEPTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ch_in      (ch_in),
    .sample_en  (sample_en),
    .arm        (arm),
    .trig_value (trig_value),
    .trig_mask  (trig_mask),
    .force_trig (force_trig),
    .post_count (post_count),
    .state      (state),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .rd_data    (rd_data),
    .rd_last    (rd_last),
    .trig_index (trig_index)
  );

  typedef struct {
    logic [15:0] start;
    logic [2:0]  post;
    logic [15:0] tv;
    logic [15:0] tm;
    int          n;
    logic [15:0] first;
    logic [2:0]  tidx;
    bit          bp;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic capture(input logic [15:0] start, input logic [2:0] post,
                         input logic [15:0] tv, input logic [15:0] tm);
    @(negedge clk);
    arm = 1'b1; post_count = post; trig_value = tv; trig_mask = tm; sample_en = 1'b0;
    @(negedge clk);
    arm = 1'b0;
    chk("armed", {30'd0, state}, 32'd1);
    ch0 = start; sample_en = 1'b1;
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      if (state == 2'd3) break;
      ch0 = ch0 + 16'd1;
    end
    sample_en = 1'b0;
    chk("readout_entry", {30'd0, state}, 32'd3);
  endtask

  task automatic read_window(input logic [15:0] first, input int n, input logic [2:0] tidx,
                             input bit bp, input int stop_at);
    int i = 0;
    logic [15:0] e;
    chk("trig_index", {29'd0, trig_index}, {29'd0, tidx});
    for (int c = 0; c < 4 * n + 8; c++) begin
      if (!rd_valid || i == stop_at) break;
      rd_ready = bp ? (c % 2 == 0) : 1'b1;
      e = first + 16'(i);
      chk("rd_data", rd_data, {~e, e});
      chk("rd_last", {31'd0, rd_last}, {31'd0, (i == n - 1)});
      if (rd_ready) i++;
      @(negedge clk);
    end
    rd_ready = 1'b0;
    if (stop_at >= n) begin
      chk("word_count", i, n);
      chk("valid_after_last", {31'd0, rd_valid}, 32'd0);
      chk("idle_after_last", {30'd0, state}, 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{16'h0001, 3'd2, 16'h0005, 16'hFFFF, 7, 16'h0001, 3'd4, 1'b0};
    tbl[1] = '{16'h0001, 3'd3, 16'h000C, 16'hFFFF, 8, 16'h0008, 3'd4, 1'b0};
    tbl[2] = '{16'h12A3, 3'd0, 16'h00A0, 16'h00F0, 1, 16'h12A3, 3'd0, 1'b0};
    tbl[3] = '{16'h0001, 3'd3, 16'h000C, 16'hFFFF, 8, 16'h0008, 3'd4, 1'b1};
    tbl[4] = '{16'h0040, 3'd5, 16'h1234, 16'h0000, 6, 16'h0040, 3'd0, 1'b0};
    tbl[5] = '{16'h0001, 3'd7, 16'h0003, 16'hFFFF, 8, 16'h0003, 3'd0, 1'b1};

    rst_n = 1'b0; ch0 = '0; sample_en = 0; arm = 0; force_trig = 0; rd_ready = 0;
    trig_value = '0; trig_mask = '0; post_count = '0;
    repeat (2) @(negedge clk);
    chk("reset_state", {30'd0, state}, 32'd0);
    chk("reset_valid", {31'd0, rd_valid}, 32'd0);
    chk("reset_data", rd_data, 32'd0);
    chk("reset_last", {31'd0, rd_last}, 32'd0);
    chk("reset_tidx", {29'd0, trig_index}, 32'd0);
    rst_n = 1'b1;

    foreach (tbl[k]) begin
      capture(tbl[k].start, tbl[k].post, tbl[k].tv, tbl[k].tm);
      read_window(tbl[k].first, tbl[k].n, tbl[k].tidx, tbl[k].bp, tbl[k].n);
    end

    // SAMPLE_EN low: neither a matching word nor FORCE_TRIG may trigger.
    @(negedge clk);
    arm = 1'b1; post_count = 3'd0; trig_value = 16'h00A0; trig_mask = 16'h00F0;
    @(negedge clk);
    arm = 1'b0; ch0 = 16'h12A3; sample_en = 1'b0; force_trig = 1'b1;
    repeat (3) @(negedge clk);
    chk("no_trig_without_en", {30'd0, state}, 32'd1);
    trig_value = 16'hFFFF; trig_mask = 16'hFFFF; ch0 = 16'h0001; sample_en = 1'b1;
    @(negedge clk);
    sample_en = 1'b0; force_trig = 1'b0;
    chk("force_trig_entry", {30'd0, state}, 32'd3);
    read_window(16'h0001, 1, 3'd0, 1'b0, 1);

    // Abort during POST.
    @(negedge clk);
    arm = 1'b1; post_count = 3'd5; trig_value = 16'h0003; trig_mask = 16'hFFFF;
    @(negedge clk);
    arm = 1'b0; ch0 = 16'h0001; sample_en = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (state == 2'd2) break;
      ch0 = ch0 + 16'd1;
    end
    chk("reached_post", {30'd0, state}, 32'd2);
    arm = 1'b1;
    @(negedge clk);
    arm = 1'b0; sample_en = 1'b0;
    chk("abort_post_state", {30'd0, state}, 32'd1);
    chk("abort_post_valid", {31'd0, rd_valid}, 32'd0);
    capture(16'h0100, 3'd2, 16'h0102, 16'hFFFF);
    read_window(16'h0100, 5, 3'd2, 1'b0, 5);

    // Abort mid-readout.
    capture(16'h0001, 3'd2, 16'h0005, 16'hFFFF);
    read_window(16'h0001, 7, 3'd4, 1'b0, 3);
    arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
    chk("abort_rd_state", {30'd0, state}, 32'd1);
    chk("abort_rd_valid", {31'd0, rd_valid}, 32'd0);
    chk("abort_rd_data", rd_data, 32'd0);
    capture(16'h0200, 3'd0, 16'h0203, 16'hFFFF);
    read_window(16'h0200, 4, 3'd3, 1'b0, 4);

    // Asynchronous reset mid-readout.
    capture(16'h0001, 3'd2, 16'h0005, 16'hFFFF);
    read_window(16'h0001, 7, 3'd4, 1'b0, 2);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_state", {30'd0, state}, 32'd0);
    chk("async_rst_valid", {31'd0, rd_valid}, 32'd0);
    chk("async_rst_data", rd_data, 32'd0);
    chk("async_rst_tidx", {29'd0, trig_index}, 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    capture(16'h12A3, 3'd0, 16'h00A0, 16'h00F0);
    read_window(16'h12A3, 1, 3'd0, 1'b0, 1);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
